// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle chunked adder/subtractor with valid/ready handshakes
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             Cin,
  input  logic             subMode,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] mySum,
  output logic             Cout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  int               base;
  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] acc_full;

  // Next-state: accept operands, add one chunk per cycle, hold the result until taken
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    bx_d      = bx_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    base      = int'(idx_q) * CHUNK;
    chunk_res = {1'b0, a_q[base +: CHUNK]} + {1'b0, bx_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    acc_full  = acc_q;
    acc_full[base +: CHUNK] = chunk_res[CHUNK-1:0];

    case (state_q)
      S_IDLE: begin
        if (inValid) begin
          // Subtraction is A + ~B + ~Cin, so invert B and the borrow-in up front
          a_d     = operandA;
          bx_d    = subMode ? ~operandB : operandB;
          carry_d = subMode ^ Cin;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        acc_d   = acc_full;
        carry_d = chunk_res[CHUNK];
        if (idx_q == LAST_IDX) begin
          sum_d   = acc_full;
          cout_d  = chunk_res[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (acc_full[WIDTH-1] != a_q[WIDTH-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (outReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      bx_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign inReady  = (state_q == S_IDLE);
  assign outValid = (state_q == S_DONE);
  assign mySum    = sum_q;
  assign Cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - directed and model-checked bench for seq_chunk_adder
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] op_a, op_b;
  logic        op_cin, op_sub, out_ready;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic        out_valid [4];
  logic [15:0] my_sum    [4];
  logic        cout      [4];
  logic        ovf       [4];

  // instance k: 0 -> CHUNK 4, 1 -> CHUNK 16, 2 -> CHUNK 1, 3 -> CHUNK 8
  int nch [4] = '{4, 1, 16, 2};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .inValid(in_valid[0]), .inReady(in_ready[0]),
    .operandA(op_a), .operandB(op_b), .Cin(op_cin), .subMode(op_sub),
    .outValid(out_valid[0]), .outReady(out_ready), .mySum(my_sum[0]),
    .Cout(cout[0]), .overflow(ovf[0]));

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .inValid(in_valid[1]), .inReady(in_ready[1]),
    .operandA(op_a), .operandB(op_b), .Cin(op_cin), .subMode(op_sub),
    .outValid(out_valid[1]), .outReady(out_ready), .mySum(my_sum[1]),
    .Cout(cout[1]), .overflow(ovf[1]));

  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .inValid(in_valid[2]), .inReady(in_ready[2]),
    .operandA(op_a), .operandB(op_b), .Cin(op_cin), .subMode(op_sub),
    .outValid(out_valid[2]), .outReady(out_ready), .mySum(my_sum[2]),
    .Cout(cout[2]), .overflow(ovf[2]));

  seq_chunk_adder #(.WIDTH(16), .CHUNK(8)) u_c8 (
    .clk(clk), .rst_n(rst_n), .inValid(in_valid[3]), .inReady(in_ready[3]),
    .operandA(op_a), .operandB(op_b), .Cin(op_cin), .subMode(op_sub),
    .outValid(out_valid[3]), .outReady(out_ready), .mySum(my_sum[3]),
    .Cout(cout[3]), .overflow(ovf[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, cout, sum}
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub);
    logic [15:0] bx;
    logic [16:0] full;
    logic        v;
    bx   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bx} + {16'd0, sub ^ cin};
    v    = (a[15] == bx[15]) && (full[15] != a[15]);
    return {v, full};
  endfunction

  // One operation on instance k; hold = cycles to stall outReady after outValid
  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input logic [15:0] e_sum,
                        input logic e_cout, input logic e_ovf, input int hold,
                        input string tag);
    int lat;
    op_a = a; op_b = b; op_cin = cin; op_sub = sub;
    in_valid[k] = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready[k]), 32'd1);
    step();
    in_valid[k] = 1'b0;
    op_a = ~a; op_b = ~b; op_cin = ~cin; op_sub = ~sub;
    lat = 0;
    while (!out_valid[k] && lat < 40) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(nch[k]));
    check({tag, ".sum"},  32'(my_sum[k]), 32'(e_sum));
    check({tag, ".cout"}, 32'(cout[k]),   32'(e_cout));
    check({tag, ".ovf"},  32'(ovf[k]),    32'(e_ovf));
    for (int i = 0; i < hold; i++) begin
      in_valid[k] = 1'b1;
      op_a = 16'($urandom); op_b = 16'($urandom);
      step();
      check({tag, ".stall_valid"}, 32'(out_valid[k]), 32'd1);
      check({tag, ".stall_ready"}, 32'(in_ready[k]),  32'd0);
      check({tag, ".stall_out"}, {14'd0, ovf[k], cout[k], my_sum[k]},
            {14'd0, e_ovf, e_cout, e_sum});
    end
    in_valid[k] = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(out_valid[k]), 32'd0);
    check({tag, ".post_ready"}, 32'(in_ready[k]),  32'd1);
    check({tag, ".retained"}, 32'(my_sum[k]), 32'(e_sum));
  endtask

  initial begin
    logic [17:0] r;
    logic [15:0] ra, rb;
    logic        rc, rs;
    int          extra;
    int          kk [3];
    for (int i = 0; i < 4; i++) in_valid[i] = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      op_a = 16'($urandom); op_b = 16'($urandom);
      op_cin = 1'($urandom); op_sub = 1'($urandom);
      in_valid[0] = 1'($urandom); out_ready = 1'($urandom);
      step();
    end
    check("rst.out_valid", 32'(out_valid[0]), 32'd0);
    check("rst.in_ready",  32'(in_ready[0]),  32'd1);
    check("rst.sum",       32'(my_sum[0]),    32'd0);
    check("rst.cout",      32'(cout[0]),      32'd0);
    check("rst.ovf",       32'(ovf[0]),       32'd0);
    in_valid[0] = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b1;
    step();

    // Directed vectors, CHUNK=4
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, "add_ffff_1");
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0, "add_7fff_1");
    run_op(0, 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 0, "add_cin");
    run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, "sub_5_7");
    run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0, "sub_8000_1");

    // Back-pressure with ignored inValid, then confirm nothing was queued
    run_op(0, 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 5, "stall");
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid[0]) extra++;
    end
    check("stall.no_queued_op", 32'(extra), 32'd0);

    // Reset on the second ADD edge aborts the operation
    op_a = 16'h1111; op_b = 16'h2222; op_cin = 1'b0; op_sub = 1'b0;
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort.sum",      32'(my_sum[0]),   32'd0);
    check("abort.in_ready", 32'(in_ready[0]), 32'd1);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid[0]) extra++;
    end
    check("abort.no_out_valid", 32'(extra), 32'd0);

    // Single-cycle configuration
    run_op(1, 16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, 0, "c16_abcd");

    // Random operations against the reference at CHUNK=1,4,8
    kk = '{2, 0, 3};
    for (int j = 0; j < 3; j++) begin
      for (int n = 0; n < 150; n++) begin
        ra = 16'($urandom); rb = 16'($urandom);
        rc = 1'($urandom);  rs = 1'($urandom);
        if (n == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; rs = 1'b0; end
        if (n == 1) begin ra = 16'h0000; rb = 16'hFFFF; rc = 1'b1; rs = 1'b1; end
        r = ref_op(ra, rb, rc, rs);
        run_op(kk[j], ra, rb, rc, rs, r[15:0], r[16], r[17], 0,
               $sformatf("rand_k%0d_%0d", kk[j], n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
